// File: rtl/dac_pkg.sv
// Shared definitions for the slewing DAC driver: FSM states, default
// geometry and the settle-counter width helper.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLEW   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } dac_state_e;

  localparam int DAC_WIDTH_DEF     = 12;
  localparam int STEP_MAX_DEF      = 64;
  localparam int SETTLE_CYCLES_DEF = 1024;
  localparam int SETTLE_CNT_W      = $clog2(SETTLE_CYCLES_DEF);

  // Counter width for a given settle length; a one-cycle settle still
  // needs a one-bit counter so the vector never collapses to zero width.
  function automatic int settle_cnt_width(input int cycles);
    if (cycles > 1) begin
      return $clog2(cycles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle hold counter: cleared on entry to the settle phase, counts while
// enabled and flags the last hold cycle.
module settle_timer
  import dac_pkg::*;
#(
  parameter int CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W  = settle_cnt_width(SETTLE_CYCLES_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Hold counter; clear wins over enable so entry always starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == LAST_CNT);

endmodule

// File: rtl/dac_slew_driver.sv
// Slew-rate-limited DAC driver: moves DAC_OUT toward an accepted target in
// bounded steps, holds for a settle period, then pulses SETTLED.
module dac_slew_driver
  import dac_pkg::*;
#(
  parameter int DAC_WIDTH     = DAC_WIDTH_DEF,
  parameter int STEP_MAX      = STEP_MAX_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic signed [DAC_WIDTH-1:0] TARGET_IN,
  input  logic                        TARGET_VALID,
  output logic                        TARGET_READY,
  output logic signed [DAC_WIDTH-1:0] DAC_OUT,
  output logic                        DAC_WE,
  output logic                        BUSY,
  output logic                        SETTLED
);

  localparam int DW1   = DAC_WIDTH + 1;
  localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES);

  // Step magnitude in the widened difference domain for comparisons.
  localparam logic signed [DW1-1:0] STEP_LIM = DW1'(STEP_MAX);
  // Step increments in the output width; modular addition is exact here
  // because a step never carries DAC_OUT past the target.
  localparam logic [DAC_WIDTH-1:0] STEP_POS = DAC_WIDTH'(STEP_MAX);
  localparam logic [DAC_WIDTH-1:0] STEP_NEG = DAC_WIDTH'(-STEP_MAX);

  dac_state_e state_r;
  dac_state_e state_nxt_s;

  logic signed [DAC_WIDTH-1:0] target_r;
  logic signed [DAC_WIDTH-1:0] dac_r;
  logic                        dac_we_r;
  logic                        busy_r;
  logic                        ready_r;
  logic                        settled_r;

  logic signed [DAC_WIDTH-1:0] dac_nxt_s;
  logic                        we_nxt_s;
  logic                        busy_nxt_s;
  logic                        ready_nxt_s;
  logic                        settled_nxt_s;

  logic                        accept_s;
  logic signed [DW1-1:0]       diff_s;
  logic                        big_s;
  logic [DAC_WIDTH-1:0]        step_s;
  logic                        timer_clear_s;
  logic                        timer_en_s;
  logic                        timer_tc_s;

  // Accept only against the registered ready, so VALID never reaches READY.
  assign accept_s = TARGET_VALID && ready_r;

  // Difference is one bit wider than the code so full-scale moves fit.
  assign diff_s = $signed({target_r[DAC_WIDTH-1], target_r})
                - $signed({dac_r[DAC_WIDTH-1], dac_r});
  assign big_s  = (diff_s > STEP_LIM) || (diff_s < -STEP_LIM);
  assign step_s = diff_s[DW1-1] ? STEP_NEG : STEP_POS;

  // Counter restarts on every entry to SETTLE and runs only inside it.
  assign timer_clear_s = (state_nxt_s == ST_SETTLE) && (state_r != ST_SETTLE);
  assign timer_en_s    = (state_r == ST_SETTLE);

  settle_timer #(
    .CYCLES (SETTLE_CYCLES),
    .CNT_W  (CNT_W)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .tc     (timer_tc_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (TARGET_IN != dac_r) begin
            state_nxt_s = ST_SLEW;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SLEW: begin
        if (big_s) begin
          state_nxt_s = ST_SLEW;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_tc_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    dac_nxt_s     = dac_r;
    we_nxt_s      = 1'b0;
    case (state_r)
      ST_SLEW: begin
        we_nxt_s = 1'b1;
        if (big_s) begin
          dac_nxt_s = dac_r + step_s;
        end else begin
          dac_nxt_s = target_r;
        end
      end
      ST_IDLE, ST_SETTLE, ST_DONE: begin
        dac_nxt_s = dac_r;
        we_nxt_s  = 1'b0;
      end
      default: begin
        dac_nxt_s = dac_r;
        we_nxt_s  = 1'b0;
      end
    endcase
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    ready_nxt_s   = (state_nxt_s == ST_IDLE);
    settled_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Registered outputs; each strobe lines up with the state it reports.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dac_r     <= '0;
      dac_we_r  <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
      settled_r <= 1'b0;
    end else begin
      dac_r     <= dac_nxt_s;
      dac_we_r  <= we_nxt_s;
      busy_r    <= busy_nxt_s;
      ready_r   <= ready_nxt_s;
      settled_r <= settled_nxt_s;
    end
  end

  // Target capture on accept; later TARGET_IN activity is ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      target_r <= '0;
    end else if (accept_s) begin
      target_r <= TARGET_IN;
    end else begin
      target_r <= target_r;
    end
  end

  assign DAC_OUT      = dac_r;
  assign DAC_WE       = dac_we_r;
  assign BUSY         = busy_r;
  assign TARGET_READY = ready_r;
  assign SETTLED      = settled_r;

endmodule

// File: tb/tb_dac_slew_driver.sv
// Directed bench for dac_slew_driver with DAC_WIDTH=12, STEP_MAX=64,
// SETTLE_CYCLES=16.
module tb_dac_slew_driver;

  localparam int W = 12;

  logic                CLK = 1'b0;
  logic                RST;
  logic signed [W-1:0] TARGET_IN;
  logic                TARGET_VALID;
  logic                TARGET_READY;
  logic signed [W-1:0] DAC_OUT;
  logic                DAC_WE;
  logic                BUSY;
  logic                SETTLED;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dac_slew_driver #(
    .DAC_WIDTH     (12),
    .STEP_MAX      (64),
    .SETTLE_CYCLES (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .TARGET_IN    (TARGET_IN),
    .TARGET_VALID (TARGET_VALID),
    .TARGET_READY (TARGET_READY),
    .DAC_OUT      (DAC_OUT),
    .DAC_WE       (DAC_WE),
    .BUSY         (BUSY),
    .SETTLED      (SETTLED)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one target from IDLE and follow the move until BUSY drops.
  task automatic do_move(input string name, input int tgt, input int exp_we,
                         input int exp_first, input int exp_mid,
                         input int exp_last, input int inject_at);
    int prev, cyc, we_cnt, mid_bad, chg_bad, last_step, first_val;
    int settled_cnt, last_evt, gap, busy_cnt, dac_now, step;
    bit done;
    prev = DAC_OUT;
    we_cnt = 0; mid_bad = 0; chg_bad = 0; last_step = 0; first_val = 0;
    settled_cnt = 0; last_evt = 0; gap = -1; done = 1'b0;
    check_val({name, "_ready_before"}, int'(TARGET_READY), 1);
    TARGET_IN    = tgt[W-1:0];
    TARGET_VALID = 1'b1;
    @(negedge CLK);
    TARGET_VALID = 1'b0;
    TARGET_IN    = 12'sd1000;
    check_val({name, "_busy_on_accept"}, int'(BUSY), 1);
    check_val({name, "_latency"}, int'(DAC_OUT), prev);
    busy_cnt = 1;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (cyc == inject_at) begin
        TARGET_VALID = 1'b1;
        TARGET_IN    = 12'sd100;
      end else if (cyc == inject_at + 1) begin
        TARGET_VALID = 1'b0;
        TARGET_IN    = 12'sd1000;
      end
      dac_now = DAC_OUT;
      if (DAC_WE) begin
        we_cnt++;
        step = dac_now - prev;
        if (we_cnt == 1) first_val = dac_now;
        if (we_cnt < exp_we && step != exp_mid) mid_bad++;
        last_step = step;
        last_evt  = cyc;
      end else if (dac_now != prev) begin
        chg_bad++;
      end
      prev = dac_now;
      if (SETTLED) begin
        settled_cnt++;
        gap = cyc - last_evt;
      end
      if (BUSY) busy_cnt++;
      else done = 1'b1;
    end
    check_val({name, "_finished"}, int'(done), 1);
    check_val({name, "_we_count"}, we_cnt, exp_we);
    check_val({name, "_final_dac"}, int'(DAC_OUT), tgt);
    check_val({name, "_settled_count"}, settled_cnt, 1);
    check_val({name, "_settle_gap"}, gap, 16);
    check_val({name, "_busy_cycles"}, busy_cnt, exp_we + 17);
    check_val({name, "_ready_after"}, int'(TARGET_READY), 1);
    check_val({name, "_silent_change"}, chg_bad, 0);
    if (exp_we > 0) begin
      check_val({name, "_first_value"}, first_val, exp_first);
      check_val({name, "_mid_steps_bad"}, mid_bad, 0);
      check_val({name, "_last_step"}, last_step, exp_last);
    end
  endtask

  int bad_we, bad_settled, bad_dac;

  initial begin
    RST          = 1'b0;
    TARGET_VALID = 1'b0;
    TARGET_IN    = '0;
    #2;
    check_val("rst_dac", int'(DAC_OUT), 0);
    check_val("rst_we", int'(DAC_WE), 0);
    check_val("rst_settled", int'(SETTLED), 0);
    check_val("rst_busy", int'(BUSY), 0);
    check_val("rst_ready", int'(TARGET_READY), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    check_val("ready_before_first_edge", int'(TARGET_READY), 0);
    @(negedge CLK);
    check_val("ready_first_edge", int'(TARGET_READY), 1);

    // 0 -> 256 with an ignored VALID pulse of 100 mid-slew
    do_move("up256", 256, 4, 64, 64, 64, 2);
    do_move("down0", 0, 4, 192, -64, -64, -1);
    do_move("neg200", -200, 4, -64, -64, -8, -1);
    do_move("same", -200, 0, 0, 0, 0, -1);
    do_move("to2047", 2047, 36, -136, 64, 7, -1);
    do_move("fullscale", -2048, 64, 1983, -64, -63, -1);

    // Reset mid-slew
    do_move("back0", 0, 32, -1984, 64, 64, -1);
    TARGET_IN    = 12'sd256;
    TARGET_VALID = 1'b1;
    @(negedge CLK);
    TARGET_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_val("mid_dac_before_reset", int'(DAC_OUT), 128);
    #2;
    RST = 1'b0;
    #1;
    check_val("mid_rst_dac", int'(DAC_OUT), 0);
    check_val("mid_rst_busy", int'(BUSY), 0);
    check_val("mid_rst_we", int'(DAC_WE), 0);
    check_val("mid_rst_ready", int'(TARGET_READY), 0);
    check_val("mid_rst_settled", int'(SETTLED), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_val("mid_rst_ready_release", int'(TARGET_READY), 1);
    bad_we = 0; bad_settled = 0; bad_dac = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DAC_WE) bad_we++;
      if (SETTLED) bad_settled++;
      if (DAC_OUT != 12'sd0) bad_dac++;
    end
    check_val("post_rst_no_we", bad_we, 0);
    check_val("post_rst_no_settled", bad_settled, 0);
    check_val("post_rst_dac_zero", bad_dac, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_slew_driver.md
DAC_SLEW_DRIVER -- requirements
Module: dac_slew_driver

Interface
REQ-001 SHALL have parameter DAC_WIDTH, default 12, DAC code width in bits (signed two's complement).
REQ-002 SHALL have parameter STEP_MAX, default 64, maximum code change per DAC update (positive, at most 2^(DAC_WIDTH-1)).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024, hold cycles after final step before SETTLED (at least 1).
REQ-004 SHALL have port CLK, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port TARGET_IN, input, DAC_WIDTH, signed requested DAC code.
REQ-007 SHALL have port TARGET_VALID, input, 1, TARGET_IN is valid.
REQ-008 SHALL have port TARGET_READY, output, 1, block can accept a target.
REQ-009 SHALL have port DAC_OUT, output, DAC_WIDTH, registered signed code presented to the DAC.
REQ-010 SHALL have port DAC_WE, output, 1, one-cycle strobe in every cycle in which DAC_OUT holds a newly changed value.
REQ-011 SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-012 SHALL have port SETTLED, output, 1, one-cycle pulse when the output is stable; this pulse starts downstream sample averaging.

Function
REQ-013 SHALL implement the states IDLE, SLEW, SETTLE and DONE.
REQ-014 SHALL drive TARGET_READY=1 only in IDLE; a target is accepted on a rising edge where TARGET_VALID and TARGET_READY are both 1.
REQ-015 SHALL capture TARGET_IN on accept; the captured target SHALL be immune to later changes on TARGET_IN.
REQ-016 SHALL, on accept, go to SLEW if the target differs from DAC_OUT, else go directly to SETTLE with no DAC_WE.
REQ-017 SHALL, in SLEW, compute diff = target - DAC_OUT in DAC_WIDTH+1 signed bits so the difference never overflows.
REQ-018 SHALL, in SLEW with |diff| > STEP_MAX, add +STEP_MAX (diff>0) or -STEP_MAX (diff<0) to DAC_OUT and stay in SLEW.
REQ-019 SHALL, in SLEW with |diff| <= STEP_MAX, load DAC_OUT with the target and go to SETTLE; DAC_OUT never overshoots the target.
REQ-020 SHALL update DAC_OUT for the first time on the edge after the accepting edge (latency 1 cycle).
REQ-021 SHALL assert DAC_WE in the cycle following each DAC_OUT update, exactly once per update.
REQ-022 SHALL clear the settle count on entry to SETTLE, increment it each SETTLE cycle, and go to DONE when the count equals SETTLE_CYCLES-1.
REQ-023 SHALL assert SETTLED for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL ignore TARGET_VALID while BUSY=1; no queuing, and DAC_OUT is unaffected.
REQ-025 SHALL keep DAC_OUT constant in IDLE, SETTLE and DONE.

Reset
REQ-026 SHALL, while RST=0 and independent of CLK, force DAC_OUT=0, DAC_WE=0, SETTLED=0, BUSY=0, TARGET_READY=0, state=IDLE, settle count=0 and captured target=0.
REQ-027 SHALL drive TARGET_READY=1 from the first rising edge after RST deasserts.
REQ-028 SHALL, on reset during SLEW or SETTLE, abandon the operation with no SETTLED pulse, and SHALL not emit any pulse after reset release.

Structure
REQ-029 SHALL take the state enumeration, default DAC_WIDTH/STEP_MAX/SETTLE_CYCLES constants and the settle-counter width ($clog2(SETTLE_CYCLES)) from a shared package dac_pkg.
REQ-030 SHALL place the settle counter in one sub-module settle_timer (inputs: clear, enable; output: terminal-count flag).
REQ-031 SHALL contain no combinational path from TARGET_VALID to TARGET_READY.

Verification (DAC_WIDTH=12, STEP_MAX=64, SETTLE_CYCLES=16)
REQ-032 SHALL pass: after reset, target 256 -> DAC_OUT 64,128,192,256 on 4 consecutive edges, 4 DAC_WE pulses, SETTLED 16 cycles after the 256 update, then TARGET_READY=1.
REQ-033 SHALL pass: from 0, target -200 -> DAC_OUT -64,-128,-192,-200; final step is 8 with no overshoot.
REQ-034 SHALL pass: target equal to current DAC_OUT -> no DAC_WE, BUSY for 17 cycles, one SETTLED pulse.
REQ-035 SHALL pass: from 2047, target -2048 -> 63 steps of -64 then a final step of -63, 64 DAC_WE pulses, no wrap-around.
REQ-036 SHALL pass: TARGET_VALID pulsed with 100 during a slew to 256 -> ignored, DAC_OUT ends at 256.
REQ-037 SHALL pass: RST low mid-slew at DAC_OUT=128 -> DAC_OUT=0 immediately, no SETTLED, TARGET_READY=1 on the first edge after release.
